ras_event_gen: RTL and testbench

Upstream feeder for the crypto return-address-stack block. Watches the retire stage for call, return and coroutine-swap instructions under the RISC-V link-register hint rules. Converts each one into push/return events (`RAS_branch`, `ret`, `RAS_addr_in`) and buffers them in a small FIFO. The pipeline stalls only when the buffer cannot absorb another instruction's events.

---
 rtl/ras_pkg.sv | 14 +
 rtl/ras_event_gen_if.sv | 9 +
 rtl/ras_evt_fifo.sv | 36 +++
 rtl/ras_event_gen.sv | 64 ++++++
 tb/tb_ras_event_gen.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/ras_pkg.sv
// ras_pkg: event types, opcodes and link-register helper shared by ras_event_gen
package ras_pkg;
  localparam int RAS_MAX_W = 64;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  typedef enum logic {EV_PUSH, EV_RET} ras_ev_kind_t;
  typedef struct packed {
    ras_ev_kind_t kind;
    logic [RAS_MAX_W-1:0] addr;
  } ras_event_t;
  function automatic logic is_link(logic [4:0] r);
    return r == 5'd1 || r == 5'd5;
  endfunction
endpackage

// File: rtl/ras_event_gen_if.sv
// ras_event_gen_if: event handshake between ras_event_gen and the return-address stack
interface ras_event_gen_if #(parameter int W = 32);
  logic RAS_branch;
  logic ret;
  logic RAS_rdy;
  logic [W-1:0] RAS_addr_in;
  modport master(output RAS_branch, ret, RAS_addr_in, input RAS_rdy);
  modport slave(input RAS_branch, ret, RAS_addr_in, output RAS_rdy);
endinterface

// File: rtl/ras_evt_fifo.sv
// ras_evt_fifo: event buffer taking up to two entries per cycle and releasing one
module ras_evt_fifo
  import ras_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] n_enq,
  input  ras_event_t din0,
  input  ras_event_t din1,
  input  logic       deq,
  output ras_event_t head,
  output logic [AW:0] count
);
  ras_event_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  // pointers wrap naturally because DEPTH is a power of two; deq is only raised when nonempty
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(n_enq);
      rp <= rp + AW'(deq);
      count <= count + (AW+1)'(n_enq) - (AW+1)'(deq);
    end
  // storage needs no reset: head is masked to zero while empty
  always_ff @(posedge clk) begin
    if (n_enq != 2'd0) mem[wp] <= din0;
    if (n_enq == 2'd2) mem[wp + AW'(1)] <= din1;
  end
  assign head = (count != '0) ? mem[rp] : '0;
endmodule

// File: rtl/ras_event_gen.sv
// ras_event_gen: turns retiring call/return/swap instructions into buffered RAS events (swap RET+PUSH when RAS_COROUTINE_EN is defined)
module ras_event_gen
  import ras_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int W = 32
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          instr_valid,
  input  logic [31:0]   instr,
  input  logic [W-1:0]  pc,
  input  logic [W-1:0]  jump_target,
  input  logic          RAS_ena,
  ras_event_gen_if.master ev,
  output logic          stall,
  output logic          overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [4:0] rd, rs1;
  logic is_jump, is_jalr, do_push, do_ret, take, deq;
  logic [1:0] n_enq;
  logic [CW-1:0] count;
  ras_event_t ev_push, ev_ret, din0, head;
  logic unused_bits;
  assign rd = instr[11:7];
  assign rs1 = instr[19:15];
  assign ev_push = '{kind: EV_PUSH, addr: RAS_MAX_W'(pc + W'(4))};
  assign ev_ret = '{kind: EV_RET, addr: RAS_MAX_W'(jump_target)};
  assign stall = count > CW'(FIFO_DEPTH - 2);
  assign deq = (count != '0) && ev.RAS_rdy;
  // link-register hint classification; a swap orders RET ahead of PUSH
  always_comb begin
    is_jalr = instr[6:0] == OP_JALR && instr[14:12] == 3'b000;
    is_jump = instr[6:0] == OP_JAL || is_jalr;
    do_push = is_jump && is_link(rd);
`ifdef RAS_COROUTINE_EN
    do_ret = is_jalr && is_link(rs1) && !(is_link(rd) && rd == rs1);
`else
    do_ret = is_jalr && is_link(rs1) && !is_link(rd);
`endif
    take = instr_valid && RAS_ena && !stall;
    n_enq = take ? 2'(do_push) + 2'(do_ret) : 2'd0;
    din0 = do_ret ? ev_ret : ev_push;
  end
  ras_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(Rst),
    .n_enq(n_enq),
    .din0(din0),
    .din1(ev_push),
    .deq(deq),
    .head(head),
    .count(count)
  );
  assign ev.RAS_branch = (count != '0) && head.kind == EV_PUSH;
  assign ev.ret = (count != '0) && head.kind == EV_RET;
  assign ev.RAS_addr_in = head.addr[W-1:0];
  assign unused_bits = ^{head.addr, instr[31:20]};
  // sticky flag for an instruction retired while the stage was told to hold
  always_ff @(posedge clk or posedge Rst)
    if (Rst) overflow <= 1'b0;
    else if (instr_valid && stall) overflow <= 1'b1;
endmodule

// File: tb/tb_ras_event_gen.sv
// tb_ras_event_gen: vector table, corner sequences and randomized reference-model check of ras_event_gen
module tb_ras_event_gen;
  localparam int D = 4;
  localparam int W = 32;
  logic clk = 0;
  logic rst = 0;
  logic instr_valid = 0;
  logic RAS_ena = 1;
  logic [31:0] instr = 0;
  logic [W-1:0] pc = 0;
  logic [W-1:0] jump_target = 0;
  logic stall, overflow;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic [31:0] ins;
    logic [W-1:0] p;
    logic [W-1:0] t;
    bit b1;
    bit r1;
    logic [W-1:0] a1;
    bit b2;
    bit r2;
    logic [W-1:0] a2;
  } vec_t;
  typedef struct {
    bit is_ret;
    logic [W-1:0] a;
  } mev_t;
  vec_t tbl[$];
  mev_t mq[$];
  bit m_ovf;
  ras_event_gen_if #(.W(W)) ev();
  ras_event_gen #(.FIFO_DEPTH(D), .W(W)) dut (
    .clk(clk),
    .Rst(rst),
    .instr_valid(instr_valid),
    .instr(instr),
    .pc(pc),
    .jump_target(jump_target),
    .RAS_ena(RAS_ena),
    .ev(ev),
    .stall(stall),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic outs(string tag, bit br, bit rt, logic [W-1:0] a);
    chk({tag, ".RAS_branch"}, 64'(ev.RAS_branch), 64'(br));
    chk({tag, ".ret"}, 64'(ev.ret), 64'(rt));
    chk({tag, ".RAS_addr_in"}, 64'(ev.RAS_addr_in), 64'(a));
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  function automatic logic [31:0] jal(logic [4:0] rd);
    return {20'h0, rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] jalr(logic [4:0] rd, logic [4:0] rs1, logic [2:0] f3);
    return {12'h0, rs1, f3, rd, 7'b1100111};
  endfunction
  function automatic int kind_of(logic [31:0] i);
    logic [4:0] rd = i[11:7];
    logic [4:0] rs = i[19:15];
    bit lrd = rd == 5'd1 || rd == 5'd5;
    bit lrs = rs == 5'd1 || rs == 5'd5;
    if (i[6:0] == 7'b1101111) return lrd ? 1 : 0;
    if (i[6:0] != 7'b1100111 || i[14:12] != 3'b000) return 0;
    if (lrd && !lrs) return 1;
    if (!lrd && lrs) return 2;
    if (lrd && lrs) return rd == rs ? 1 : 3;
    return 0;
  endfunction
  function automatic logic [4:0] rreg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      default: return 5'($urandom_range(2, 31));
    endcase
  endfunction
  initial begin
    bit rdy_r, ena_r, val_r, st_r, br_e, rt_e;
    int k, sel;
    logic [31:0] r;
    logic [W-1:0] a_e, p4;
    ev.RAS_rdy = 0;
    #2 rst = 1;
    #1;
    outs("reset", 0, 0, 0);
    chk("reset.stall", 64'(stall), 0);
    chk("reset.overflow", 64'(overflow), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    ev.RAS_rdy = 1;
    tbl.push_back('{jal(5'd1), 32'h100, 32'h400, 1, 0, 32'h104, 0, 0, 0});
    tbl.push_back('{jalr(5'd0, 5'd1, 3'd0), 32'h404, 32'h104, 0, 1, 32'h104, 0, 0, 0});
`ifdef RAS_COROUTINE_EN
    tbl.push_back('{jalr(5'd5, 5'd1, 3'd0), 32'h200, 32'h300, 0, 1, 32'h300, 1, 0, 32'h204});
`else
    tbl.push_back('{jalr(5'd5, 5'd1, 3'd0), 32'h200, 32'h300, 1, 0, 32'h204, 0, 0, 0});
`endif
    tbl.push_back('{jal(5'd0), 32'h100, 32'h400, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{jal(5'd5), 32'hFFFF_FFFC, 32'h8, 1, 0, 32'h0, 0, 0, 0});
    tbl.push_back('{jalr(5'd1, 5'd1, 3'd0), 32'h50, 32'h90, 1, 0, 32'h54, 0, 0, 0});
    tbl.push_back('{jalr(5'd1, 5'd6, 3'd0), 32'h60, 32'h90, 1, 0, 32'h64, 0, 0, 0});
    tbl.push_back('{jalr(5'd0, 5'd5, 3'd0), 32'h70, 32'h777, 0, 1, 32'h777, 0, 0, 0});
    tbl.push_back('{jalr(5'd0, 5'd1, 3'd1), 32'h80, 32'h90, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{jalr(5'd2, 5'd3, 3'd0), 32'h80, 32'h90, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{32'h0010_0093, 32'h80, 32'h90, 0, 0, 0, 0, 0, 0});
    foreach (tbl[i]) begin
      instr_valid = 1;
      instr = tbl[i].ins;
      pc = tbl[i].p;
      jump_target = tbl[i].t;
      tick();
      instr_valid = 0;
      outs($sformatf("vec%0d.first", i), tbl[i].b1, tbl[i].r1, tbl[i].a1);
      tick();
      outs($sformatf("vec%0d.second", i), tbl[i].b2, tbl[i].r2, tbl[i].a2);
      tick();
    end
    ev.RAS_rdy = 0;
    for (int j = 1; j <= 3; j++) begin
      instr_valid = 1;
      instr = jal(5'd1);
      pc = W'(j * 16);
      tick();
      chk($sformatf("bp.stall%0d", j), 64'(stall), 64'(j == 3));
    end
    outs("bp.hold", 1, 0, 32'h14);
    pc = 32'h40;
    tick();
    instr_valid = 0;
    chk("ovf.set", 64'(overflow), 1);
    chk("ovf.stall", 64'(stall), 1);
    outs("ovf.head", 1, 0, 32'h14);
    ev.RAS_rdy = 1;
    tick();
    outs("bp.drain1", 1, 0, 32'h24);
    chk("bp.stall_fall", 64'(stall), 0);
    tick();
    outs("bp.drain2", 1, 0, 32'h34);
    tick();
    outs("bp.empty", 0, 0, 0);
    chk("ovf.sticky", 64'(overflow), 1);
    RAS_ena = 0;
    instr_valid = 1;
    instr = jal(5'd1);
    pc = 32'h500;
    tick();
    instr_valid = 0;
    RAS_ena = 1;
    outs("bypass", 0, 0, 0);
    ev.RAS_rdy = 0;
    instr_valid = 1;
    pc = 32'h600;
    tick();
    pc = 32'h610;
    tick();
    instr_valid = 0;
    outs("rst.pre", 1, 0, 32'h604);
    #2 rst = 1;
    #1;
    outs("rst.async", 0, 0, 0);
    chk("rst.overflow", 64'(overflow), 0);
    chk("rst.stall", 64'(stall), 0);
    @(negedge clk);
    rst = 0;
    ev.RAS_rdy = 1;
    tick();
    outs("rst.after1", 0, 0, 0);
    tick();
    outs("rst.after2", 0, 0, 0);
    m_ovf = 0;
    for (int c = 0; c < 3000; c++) begin
      br_e = mq.size() > 0 && !mq[0].is_ret;
      rt_e = mq.size() > 0 && mq[0].is_ret;
      a_e = mq.size() > 0 ? mq[0].a : '0;
      st_r = mq.size() > D - 2;
      outs($sformatf("rnd%0d", c), br_e, rt_e, a_e);
      chk($sformatf("rnd%0d.stall", c), 64'(stall), 64'(st_r));
      chk($sformatf("rnd%0d.overflow", c), 64'(overflow), 64'(m_ovf));
      rdy_r = $urandom_range(0, 3) != 0;
      ena_r = $urandom_range(0, 7) != 0;
      val_r = st_r ? $urandom_range(0, 19) == 0 : $urandom_range(0, 1) == 1;
      r = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 3) instr = jal(rreg()) | (r & 32'hFFFF_F000);
      else if (sel < 9) instr = jalr(rreg(), rreg(), $urandom_range(0, 4) == 0 ? 3'($urandom) : 3'd0) | (r & 32'hFFF0_0000);
      else instr = r;
      pc = W'($urandom);
      jump_target = W'($urandom);
      ev.RAS_rdy = rdy_r;
      RAS_ena = ena_r;
      instr_valid = val_r;
      @(posedge clk);
      if (mq.size() > 0 && rdy_r) void'(mq.pop_front());
      p4 = pc + W'(4);
      if (val_r && st_r) m_ovf = 1;
      else if (val_r && ena_r) begin
        k = kind_of(instr);
        if (k == 1) mq.push_back('{0, p4});
        if (k == 2) mq.push_back('{1, jump_target});
`ifdef RAS_COROUTINE_EN
        if (k == 3) begin
          mq.push_back('{1, jump_target});
          mq.push_back('{0, p4});
        end
`else
        if (k == 3) mq.push_back('{0, p4});
`endif
      end
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
